led_blink_sink: RTL and testbench
=================================

// Module: led_blink_sink
// PURPOSE
//   Consumer end of the single-cycle valid/ready event handshake. Accepts one request
//   (a blink count), drives a board LED for that many on/off blinks, then re-asserts ready.
//   Sits downstream of any valid/ready event source (e.g. debounced button events) as visible feedback.
// PARAMETERS
//   ON_CYCLES       12_000_000  clk cycles LED is lit per blink (>=1)
//   OFF_CYCLES      12_000_000  clk cycles LED is dark after each blink (>=1)
//   COUNT_WIDTH     4           width of blink-count request field
//   LED_ACTIVE_LOW  0           1: led pin driven low when lit
// PORTS
//   clk     in   1            single clock, all logic on posedge
//   reset   in   1            synchronous, active-high; sampled on posedge clk
//   valid   in   1            request present
//   count   in   COUNT_WIDTH  blinks requested; sampled only on transfer
//   ready   out  1            sink idle and able to accept
//   busy    out  1            blink sequence in progress (= !ready)
//   led     out  1            LED pin, polarity per LED_ACTIVE_LOW
// BEHAVIOUR
//   - Transfer: valid==YES && ready==YES at a posedge. Nothing else has effect; valid may drop
//     at any time without a transfer; count ignored outside transfer cycle.
//   - ready is decoded from state (IDLE -> YES); no combinational path valid->ready.
//   - Reset (and initial value): state IDLE, ready=YES, busy=NO, led dark, timer=0, remaining=0.
//   - States: IDLE, ON, OFF.
//     IDLE: on transfer with count>0 -> ON, remaining<=count, timer<=ON_CYCLES-1, led lit.
//           on transfer with count==0 -> stays IDLE; request consumed, led untouched, ready stays YES.
//     ON:   timer counts down; at timer==0 -> OFF, timer<=OFF_CYCLES-1, led dark, remaining--.
//     OFF:  timer counts down; at timer==0 -> remaining!=0 ? ON (reload ON_CYCLES-1, led lit)
//                                          : IDLE.
//   - Timing: transfer at edge k -> led lit cycles k+1..k+ON_CYCLES, dark for next OFF_CYCLES;
//     ready low for exactly count*(ON_CYCLES+OFF_CYCLES) cycles, high again after edge
//     k+count*(ON_CYCLES+OFF_CYCLES); a new transfer may occur on that same cycle.
//   - Widths: timer $clog2(max(ON_CYCLES,OFF_CYCLES)); remaining COUNT_WIDTH; count of
//     all-ones (max) is legal, no wrap; remaining never decremented below 0.
//   - led registered, glitch-free; polarity inversion applied at output only.
//   - Reset mid-sequence: next cycle IDLE, led dark, pending blinks discarded, ready=YES.
//   - Reset and valid in same cycle: reset wins, no transfer.
// STRUCTURE
//   - Shared package: YES/NO constants; blink_state_t enum {IDLE, ON, OFF}.
//   - One sub-module: cycle_timer (loadable down-counter, WIDTH param, load/value in,
//     done out when value==0); FSM, remaining counter and led register in this module.
// TESTING  (ON_CYCLES=4, OFF_CYCLES=2, COUNT_WIDTH=4, LED_ACTIVE_LOW=0 unless noted)
//   1. Hold reset 3 cycles -> ready=1, busy=0, led=0 throughout and on release.
//   2. valid=1,count=3 one cycle -> led pattern 1111 00 x3, ready low exactly 18 cycles, then 1.
//   3. valid=1,count=0 -> transfer, led stays 0, ready never drops.
//   4. valid held high, count=1, count changed to 7 mid-sequence -> transfers every 6 cycles,
//      each exactly one blink (count sampled only at transfer).
//   5. count=2, reset during second ON phase -> next cycle led=0, ready=1, no further blink.
//   6. LED_ACTIVE_LOW=1, count=15 -> led pin inverted, 15 blinks, ready low 90 cycles.

Source files
------------

// File: rtl/led_blink_sink_pkg.sv
// Shared definitions for the LED blink sink: handshake levels, FSM states
// and the timer width helper.
package led_blink_sink_pkg;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Bits needed to hold the larger of the two phase reloads (ON-1 / OFF-1).
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int w_max;
        int w_bits;
        w_max  = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        w_bits = $clog2(w_max);
        return (w_bits < 1) ? 1 : w_bits;
    endfunction

endpackage

// File: rtl/led_blink_sink_timer.sv
// Loadable down-counter: counts toward zero, holds at zero, done while zero.
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_value;
        end else if (r_value != '0) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign o_done = (r_value == '0);

endmodule

// File: rtl/led_blink_sink.sv
// Valid/ready sink that turns each accepted blink count into that many
// ON_CYCLES-lit / OFF_CYCLES-dark LED pulses, then returns to idle.
module led_blink_sink
    import led_blink_sink_pkg::*;
#(
    parameter int ON_CYCLES      = 12_000_000,
    parameter int OFF_CYCLES     = 12_000_000,
    parameter int COUNT_WIDTH    = 4,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   ready,
    output logic                   busy,
    output logic                   led
);

    localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    blink_state_t           r_state;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_led_lit;

    logic          w_transfer;
    logic          w_timer_load;
    logic [TW-1:0] w_timer_load_value;
    logic          w_timer_done;

    assign w_transfer = valid && ready;

    // Timer reloads happen on exactly the edges where the FSM changes phase.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_timer_load       = NO;
        w_timer_load_value = '0;
        case (r_state)
            IDLE: begin
                if (w_transfer && (count != '0)) begin
                    w_timer_load       = YES;
                    w_timer_load_value = ON_LOAD;
                end
            end
            ON: begin
                if (w_timer_done) begin
                    w_timer_load       = YES;
                    w_timer_load_value = OFF_LOAD;
                end
            end
            OFF: begin
                if (w_timer_done && (r_remaining != '0)) begin
                    w_timer_load       = YES;
                    w_timer_load_value = ON_LOAD;
                end
            end
            default: ;
        endcase
    end

    cycle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_load_value),
        .o_done       (w_timer_done)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_led_lit   <= NO;
        end else begin
            case (r_state)
                IDLE: begin
                    // A zero count is still consumed, it just produces no blink.
                    if (w_transfer && (count != '0)) begin
                        r_state     <= ON;
                        r_remaining <= count;
                        r_led_lit   <= YES;
                    end
                end
                ON: begin
                    if (w_timer_done) begin
                        r_state   <= OFF;
                        r_led_lit <= NO;
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (w_timer_done) begin
                        if (r_remaining != '0) begin
                            r_state   <= ON;
                            r_led_lit <= YES;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_led_lit <= NO;
                end
            endcase
        end
    end

    assign ready = (r_state == IDLE) ? YES : NO;
    assign busy  = !ready;
    assign led   = LED_ACTIVE_LOW ? !r_led_lit : r_led_lit;

endmodule

// File: tb/tb_led_blink_sink.sv
// Directed bench for led_blink_sink with short phases (ON=4, OFF=2); a second
// instance with an active-low LED pin covers the maximum count.
module tb_led_blink_sink;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [3:0] count;
    logic       ready;
    logic       busy;
    logic       led;

    logic       valid_b;
    logic [3:0] count_b;
    logic       ready_b;
    logic       busy_b;
    logic       led_b;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    led_blink_sink #(
        .ON_CYCLES      (4),
        .OFF_CYCLES     (2),
        .COUNT_WIDTH    (4),
        .LED_ACTIVE_LOW (1'b0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .count (count),
        .ready (ready),
        .busy  (busy),
        .led   (led)
    );

    led_blink_sink #(
        .ON_CYCLES      (4),
        .OFF_CYCLES     (2),
        .COUNT_WIDTH    (4),
        .LED_ACTIVE_LOW (1'b1)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .valid (valid_b),
        .count (count_b),
        .ready (ready_b),
        .busy  (busy_b),
        .led   (led_b)
    );

    task automatic check(input string tag, input logic observed, input logic expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatch++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle before touching inputs or sampling outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 1'b0;
        count   = 4'd0;
        valid_b = 1'b0;
        count_b = 4'd0;

        // 1. Reset held three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t1_ready[%0d]", i), ready, 1'b1);
            check($sformatf("t1_busy[%0d]", i), busy, 1'b0);
            check($sformatf("t1_led[%0d]", i), led, 1'b0);
            check($sformatf("t1_led_b[%0d]", i), led_b, 1'b1);
        end
        reset = 1'b0;
        tick();
        check("t1_ready_rel", ready, 1'b1);
        check("t1_busy_rel", busy, 1'b0);
        check("t1_led_rel", led, 1'b0);

        // 2. Three blinks: 1111 00 repeated, ready low for 18 cycles.
        valid = 1'b1;
        count = 4'd3;
        tick();
        valid = 1'b0;
        count = 4'd0;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("t2_led[%0d]", i), led, logic'((i % 6) < 4));
            check($sformatf("t2_ready[%0d]", i), ready, 1'b0);
            check($sformatf("t2_busy[%0d]", i), busy, 1'b1);
            tick();
        end
        check("t2_ready_end", ready, 1'b1);
        check("t2_led_end", led, 1'b0);

        // 3. Zero count is consumed without any blink or ready drop.
        valid = 1'b1;
        count = 4'd0;
        check("t3_ready_pre", ready, 1'b1);
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_ready[%0d]", i), ready, 1'b1);
            check($sformatf("t3_led[%0d]", i), led, 1'b0);
            tick();
        end

        // 4. valid held high; count changes while busy must not matter.
        valid = 1'b1;
        count = 4'd1;
        for (int r = 0; r < 3; r++) begin
            tick();
            for (int i = 0; i < 6; i++) begin
                check($sformatf("t4_led[%0d][%0d]", r, i), led, logic'(i < 4));
                check($sformatf("t4_ready[%0d][%0d]", r, i), ready, 1'b0);
                if (i == 2) count = 4'd7;
                if (i == 5) count = 4'd1;
                tick();
            end
            check($sformatf("t4_ready_end[%0d]", r), ready, 1'b1);
            check($sformatf("t4_led_end[%0d]", r), led, 1'b0);
        end
        valid = 1'b0;
        tick();
        check("t4_ready_idle", ready, 1'b1);
        check("t4_led_idle", led, 1'b0);

        // 5. Reset in the second ON phase, with valid also high on that edge.
        valid = 1'b1;
        count = 4'd2;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t5_led_second_on", led, 1'b1);
        check("t5_busy_second_on", busy, 1'b1);
        reset = 1'b1;
        valid = 1'b1;
        count = 4'd5;
        tick();
        reset = 1'b0;
        valid = 1'b0;
        check("t5_ready_rst", ready, 1'b1);
        check("t5_busy_rst", busy, 1'b0);
        check("t5_led_rst", led, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("t5_led_after[%0d]", i), led, 1'b0);
            check($sformatf("t5_ready_after[%0d]", i), ready, 1'b1);
        end

        // 6. Active-low instance, maximum count of 15: 90 busy cycles.
        valid_b = 1'b1;
        count_b = 4'd15;
        tick();
        valid_b = 1'b0;
        count_b = 4'd0;
        for (int i = 0; i < 90; i++) begin
            check($sformatf("t6_led_b[%0d]", i), led_b, logic'((i % 6) >= 4));
            check($sformatf("t6_ready_b[%0d]", i), ready_b, 1'b0);
            check($sformatf("t6_busy_b[%0d]", i), busy_b, 1'b1);
            tick();
        end
        check("t6_ready_b_end", ready_b, 1'b1);
        check("t6_busy_b_end", busy_b, 1'b0);
        check("t6_led_b_end", led_b, 1'b1);
        check("t6_led_a_quiet", led, 1'b0);
        check("t6_ready_a_quiet", ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
